// File: rtl/alu_seq_unit.sv
// ALU decode/execute unit: one-cycle logic/arithmetic ops, shifts either iterative (1 bit/cycle)
// or single-cycle barrel, with valid/ready handshakes on request and result sides.
module alu_seq_unit #(
  parameter int XLEN       = 32,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_operation,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      control
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              zero_q, zero_d;
  logic              live_q, live_d;

  logic [3:0]        dec_ctrl;
  logic [XLEN-1:0]   exec_res;
  logic [XLEN-1:0]   step_res;
  logic [SHW-1:0]    shamt;
  logic              is_shift;
  logic              imm_form;
  logic              f7_zero;
  logic              f7_alt;

  assign shamt    = op_b[SHW-1:0];
  assign imm_form = (alu_operation == 2'b11);
  assign f7_zero  = (func7 == 7'b0000000);
  assign f7_alt   = (func7 == 7'b0100000);

  // I-type ignores func7 except for the shift encodings
  always_comb begin
    dec_ctrl = C_ILL;
    case (alu_operation)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      default: begin
        case (func3)
          3'b000: if (imm_form || f7_zero) dec_ctrl = C_ADD;
                  else if (f7_alt)         dec_ctrl = C_SUB;
          3'b001: if (f7_zero)             dec_ctrl = C_SLL;
          3'b010: if (imm_form || f7_zero) dec_ctrl = C_SLT;
          3'b011: if (imm_form || f7_zero) dec_ctrl = C_SLTU;
          3'b100: if (imm_form || f7_zero) dec_ctrl = C_XOR;
          3'b101: if (f7_zero)             dec_ctrl = C_SRL;
                  else if (f7_alt)         dec_ctrl = C_SRA;
          3'b110: if (imm_form || f7_zero) dec_ctrl = C_OR;
          default: if (imm_form || f7_zero) dec_ctrl = C_AND;
        endcase
      end
    endcase
  end

  assign is_shift = (dec_ctrl == C_SLL) || (dec_ctrl == C_SRL) || (dec_ctrl == C_SRA);

  always_comb begin
    exec_res = '0;
    case (dec_ctrl)
      C_AND:  exec_res = op_a & op_b;
      C_OR:   exec_res = op_a | op_b;
      C_ADD:  exec_res = op_a + op_b;
      C_XOR:  exec_res = op_a ^ op_b;
      C_SUB:  exec_res = op_a - op_b;
      C_SLT:  exec_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_SLTU: exec_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      C_SLL:  exec_res = op_a << shamt;
      C_SRL:  exec_res = op_a >> shamt;
      C_SRA:  exec_res = $unsigned($signed(op_a) >>> shamt);
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    step_res = acc_q;
    case (ctrl_q)
      C_SLL:   step_res = {acc_q[XLEN-2:0], 1'b0};
      C_SRL:   step_res = {1'b0, acc_q[XLEN-1:1]};
      C_SRA:   step_res = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: step_res = acc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    zero_d    = zero_q;
    live_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          ctrl_d    = dec_ctrl;
          illegal_d = (dec_ctrl == C_ILL);
          cnt_d     = shamt;
          if (is_shift && !FAST_SHIFT && (shamt != '0)) begin
            acc_d   = op_a;
            state_d = S_SHIFT;
          end else begin
            acc_d   = exec_res;
            zero_d  = (exec_res == '0);
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        acc_d = step_res;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          zero_d  = (step_res == '0);
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ctrl_q    <= 4'b0000;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      live_q    <= live_d;
    end
  end

  // live_q keeps in_ready low until the first edge after reset is released
  assign in_ready  = live_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = acc_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign control   = ctrl_q;
endmodule
